// File: rtl/rr_logb_flow_ctrl.sv
// -----------------------------------------------------------------------------
// rr_logb_flow_ctrl
//
// Flow controller between the top of the packed logging-bus merge tree and the
// trace FIFO that stores packed logb frames. The merge tree ignores almful and
// takes PIPE_STAGES cycles forward, and almful takes another PIPE_STAGES cycles
// to reach the loggers. logb_almful is therefore raised with 2*PIPE_STAGES+SLACK
// entries of headroom, so frames already in flight can still be absorbed.
//
// The block tracks FIFO occupancy, sequences software flushes, and keeps sticky
// overflow/underflow flags.
//
// Ports:
//   clk           clock
//   rstn          asynchronous active-low reset
//   fifo_push     a frame is written to the trace FIFO this cycle
//   fifo_pop      an entry is read from the trace FIFO this cycle
//   flush_req     level request to drain the logging path
//   overflow_clr  clears overflow/underflow; leaves OVF for THROTTLE
//   logb_almful   almost-full to the loggers (registered)
//   occupancy     current FIFO entry count (registered)
//   flush_done    one-cycle pulse when a flush completes (registered)
//   overflow      sticky: push arrived while full
//   underflow     sticky: pop arrived while empty
//   busy_drain    high while in DRAIN (registered)
// -----------------------------------------------------------------------------
module rr_logb_flow_ctrl #(
  parameter int FIFO_DEPTH  = 512,
  parameter int PIPE_STAGES = 4,
  parameter int SLACK       = 2,
  parameter int HYST        = 4,
  parameter int CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             fifo_push,
  input  logic             fifo_pop,
  input  logic             flush_req,
  input  logic             overflow_clr,
  output logic             logb_almful,
  output logic [CNT_W-1:0] occupancy,
  output logic             flush_done,
  output logic             overflow,
  output logic             underflow,
  output logic             busy_drain
);

  // Raise almful at TH; drop it again only below TL.
  localparam int HEADROOM = 2 * PIPE_STAGES + SLACK;
  localparam int TH       = FIFO_DEPTH - HEADROOM;
  localparam int TL       = TH - HYST;

  // Number of push-free cycles that proves the merge tree has emptied.
  localparam int QMAX = PIPE_STAGES + SLACK;
  localparam int Q_W  = (QMAX < 1) ? 1 : $clog2(QMAX + 1);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] TH_C    = CNT_W'(TH);
  localparam logic [CNT_W-1:0] TL_C    = CNT_W'(TL);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [Q_W-1:0]   QMAX_C  = Q_W'(QMAX);
  localparam logic [Q_W-1:0]   Q_ONE   = Q_W'(1);

  if (TL < 1) begin : g_bad_params
    $error("rr_logb_flow_ctrl: FIFO_DEPTH too small for PIPE_STAGES, SLACK and HYST");
  end

  typedef enum logic [1:0] {
    RUN,
    THROTTLE,
    DRAIN,
    OVF
  } state_t;

  state_t           state;
  logic [Q_W-1:0]   quiet;

  logic             push_acc;
  logic             pop_acc;
  logic             ovf_evt;
  logic             udf_evt;
  logic [CNT_W-1:0] occ_next;

  // Acceptance and next occupancy. A push at full is still accepted when a pop
  // frees a slot in the same cycle; a pop at empty is never accepted.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pop_acc  = fifo_pop && (occupancy != '0);
    push_acc = fifo_push && ((occupancy < DEPTH_C) || pop_acc);
    ovf_evt  = fifo_push && !push_acc;
    udf_evt  = fifo_pop && !pop_acc;
    occ_next = occupancy;
    if (push_acc && !pop_acc) begin
      occ_next = occupancy + CNT_ONE;
    end else if (pop_acc && !push_acc) begin
      occ_next = occupancy - CNT_ONE;
    end
  end

  // FSM and all registered outputs. logb_almful and busy_drain are written
  // alongside every state change so they always describe the next state.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: async reset forces every flop at once; state uses non-blocking assignments only.
    if (!rstn) begin
      state       <= RUN;
      quiet       <= '0;
      occupancy   <= '0;
      logb_almful <= 1'b0;
      flush_done  <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      busy_drain  <= 1'b0;
    end else begin
      occupancy  <= occ_next;
      flush_done <= 1'b0;

      // Underflow: set wins over a simultaneous clear.
      if (udf_evt) begin
        underflow <= 1'b1;
      end else if (overflow_clr) begin
        underflow <= 1'b0;
      end

      if (ovf_evt) begin
        // A dropped push outranks everything, including a pending flush.
        state       <= OVF;
        overflow    <= 1'b1;
        logb_almful <= 1'b1;
        busy_drain  <= 1'b0;
      end else begin
        unique case (state)
          OVF: begin
            logb_almful <= 1'b1;
            if (overflow_clr) begin
              state    <= THROTTLE;
              overflow <= 1'b0;
            end
          end

          RUN, THROTTLE: begin
            if (flush_req) begin
              state       <= DRAIN;
              quiet       <= '0;
              logb_almful <= 1'b1;
              busy_drain  <= 1'b1;
            end else if ((state == RUN) && (occ_next >= TH_C)) begin
              state       <= THROTTLE;
              logb_almful <= 1'b1;
            end else if ((state == THROTTLE) && (occ_next < TL_C)) begin
              state       <= RUN;
              logb_almful <= 1'b0;
            end
          end

          DRAIN: begin
            if (fifo_push) begin
              quiet <= '0;
            end else if (quiet != QMAX_C) begin
              quiet <= quiet + Q_ONE;
            end

            if (flush_done) begin
              // The done pulse was shown while still in DRAIN; leave now.
              busy_drain <= 1'b0;
              if (occ_next >= TH_C) begin
                state       <= THROTTLE;
                logb_almful <= 1'b1;
              end else begin
                state       <= RUN;
                logb_almful <= 1'b0;
              end
            end else if ((quiet == QMAX_C) && (occ_next == '0)) begin
              flush_done <= 1'b1;
            end
          end

          default: begin
            state <= RUN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rr_logb_flow_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rr_logb_flow_ctrl
//
// Directed bench for rr_logb_flow_ctrl with FIFO_DEPTH=16, PIPE_STAGES=2,
// SLACK=1, HYST=2 (TH=11, TL=9, quiet limit 3). Each stimulus step drives the
// inputs on a falling edge and queues the hand-computed outputs expected after
// the next rising edge; an independent monitor pops the queue just after every
// rising edge and compares.
// -----------------------------------------------------------------------------
module tb_rr_logb_flow_ctrl;

  localparam int FIFO_DEPTH  = 16;
  localparam int PIPE_STAGES = 2;
  localparam int SLACK       = 1;
  localparam int HYST        = 2;
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);

  logic             clk = 1'b0;
  logic             rstn = 1'b1;
  logic             fifo_push = 1'b0;
  logic             fifo_pop = 1'b0;
  logic             flush_req = 1'b0;
  logic             overflow_clr = 1'b0;
  logic             logb_almful;
  logic [CNT_W-1:0] occupancy;
  logic             flush_done;
  logic             overflow;
  logic             underflow;
  logic             busy_drain;

  rr_logb_flow_ctrl #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .PIPE_STAGES(PIPE_STAGES),
    .SLACK      (SLACK),
    .HYST       (HYST)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .fifo_push   (fifo_push),
    .fifo_pop    (fifo_pop),
    .flush_req   (flush_req),
    .overflow_clr(overflow_clr),
    .logb_almful (logb_almful),
    .occupancy   (occupancy),
    .flush_done  (flush_done),
    .overflow    (overflow),
    .underflow   (underflow),
    .busy_drain  (busy_drain)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   occ;
    logic alm;
    logic fd;
    logic ovf;
    logic udf;
    logic busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   mon_idx  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check($sformatf("%s occupancy", tag), 32'(occupancy), e.occ);
    check($sformatf("%s logb_almful", tag), 32'(logb_almful), 32'(e.alm));
    check($sformatf("%s flush_done", tag), 32'(flush_done), 32'(e.fd));
    check($sformatf("%s overflow", tag), 32'(overflow), 32'(e.ovf));
    check($sformatf("%s underflow", tag), 32'(underflow), 32'(e.udf));
    check($sformatf("%s busy_drain", tag), 32'(busy_drain), 32'(e.busy));
  endtask

  // Monitor: compares the registered outputs just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        mon_idx++;
        check_all($sformatf("step%0d", mon_idx), e);
      end
    end
  end

  // One clock of stimulus plus the outputs expected after the next rising edge.
  task automatic step(input logic push, input logic pop, input logic flush, input logic clr,
                      input int occ, input logic alm, input logic fd, input logic ovf,
                      input logic udf, input logic busy);
    exp_t e;
    @(negedge clk);
    fifo_push    = push;
    fifo_pop     = pop;
    flush_req    = flush;
    overflow_clr = clr;
    e.occ  = occ;
    e.alm  = alm;
    e.fd   = fd;
    e.ovf  = ovf;
    e.udf  = udf;
    e.busy = busy;
    exp_q.push_back(e);
  endtask

  // Idle the inputs and wait (bounded) for the monitor to consume everything.
  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;
    flush_req    = 1'b0;
    overflow_clr = 1'b0;
    while ((exp_q.size() > 0) && (n < 20)) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Assert reset between clock edges and check that outputs clear immediately.
  task automatic mid_reset(input string tag);
    exp_t z;
    z.occ = 0; z.alm = 1'b0; z.fd = 1'b0; z.ovf = 1'b0; z.udf = 1'b0; z.busy = 1'b0;
    drain();
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check_all(tag, z);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    exp_t z;
    z.occ = 0; z.alm = 1'b0; z.fd = 1'b0; z.ovf = 1'b0; z.udf = 1'b0; z.busy = 1'b0;

    // Reset at power-up, asserted between edges.
    #2;
    rstn = 1'b0;
    #1;
    check_all("init_reset", z);
    @(negedge clk);
    rstn = 1'b1;

    // Threshold: almful after the 11th push, hysteresis down to occ 8.
    for (int i = 1; i <= 11; i++) step(1, 0, 0, 0, i, (i >= 11), 0, 0, 0, 0);
    step(0, 1, 0, 0, 10, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0,  9, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0,  8, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0,  8, 0, 0, 0, 0, 0);

    // Full and overflow.
    for (int i = 9; i <= 16; i++) step(1, 0, 0, 0, i, (i >= 11), 0, 0, 0, 0);
    step(1, 1, 0, 0, 16, 1, 0, 0, 0, 0);  // push+pop at full: no overflow
    step(1, 0, 0, 0, 16, 1, 0, 1, 0, 0);  // push at full: overflow, OVF
    step(0, 0, 1, 0, 16, 1, 0, 1, 0, 0);  // flush ignored in OVF
    step(0, 0, 0, 1, 16, 1, 0, 0, 0, 0);  // clear -> THROTTLE
    step(0, 0, 0, 0, 16, 1, 0, 0, 0, 0);

    // Asynchronous reset from THROTTLE at full.
    mid_reset("reset_from_full");

    // Flush with a push inside the drain window.
    step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 2, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 3, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 3, 1, 0, 0, 0, 1);   // enter DRAIN
    step(1, 0, 0, 0, 4, 1, 0, 0, 0, 1);   // push resets quiet counter
    step(0, 1, 0, 0, 3, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 2, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1, 1, 0, 0, 1);   // quiet=3 and empty: done pulse
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // back in RUN

    // Underflow.
    step(0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Flush from empty with flush_req held: done after exactly 3 quiet cycles,
    // then a second flush starts straight from RUN.
    step(0, 0, 1, 0, 0, 1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1, 0, 0, 0, 1);

    // Reset mid-DRAIN with occ=5.
    for (int i = 1; i <= 5; i++) step(1, 0, 0, 0, i, 1, 0, 0, 0, 1);
    mid_reset("reset_in_drain");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);   // RUN: no almful, no busy

    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
